iiitb_rv32i_ifetch: RTL and testbench

//  Instruction-fetch front end ahead of decode: owns the PC and issues in-order

---
 rtl/iiitb_rv32i_ifetch.sv | 222 ++++++++++++++++++++++
 tb/tb_iiitb_rv32i_ifetch.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iiitb_rv32i_ifetch.sv
// ----------------------------------------------------------------------------
// iiitb_rv32i_ifetch
//
// Instruction-fetch front end. It owns the PC and issues in-order word reads
// to the instruction memory. Each returned word is buffered in a small
// prefetch FIFO together with its next-PC (NPC). Decode takes the buffered
// words over a valid/ready handshake. A taken-branch redirect from EX
// flushes the buffered words and retargets the PC. Reads that were already
// in flight when the redirect arrived are discarded as they return.
//
// The number of buffered words plus the number of outstanding reads never
// exceeds FIFO_DEPTH. This credit rule means an arriving response always
// finds space in the FIFO.
//
// Optional feature: define IFETCH_PERF_CNT_EN to add two saturating
// performance counters, o_perf_fetched and o_perf_flushed.
//
// Ports
//   i_clk           clock, all logic on posedge
//   i_rst           synchronous active-high reset
//   o_imem_req      read request, at most one word per cycle
//   o_imem_addr     word address of the request (truncated PC)
//   i_imem_ready    memory accepts the request this cycle
//   i_imem_rvalid   read data valid (in order, latency >= 1)
//   i_imem_rdata    returned instruction word
//   i_br_taken      one-cycle redirect strobe from EX
//   i_br_target     redirect target (word address)
//   o_if_valid      instruction/NPC valid towards decode
//   i_if_ready      decode accepts the instruction
//   o_if_instr      instruction word at the FIFO head
//   o_if_npc        address of that instruction + 1
//   o_perf_fetched  (IFETCH_PERF_CNT_EN) decode handshakes
//   o_perf_flushed  (IFETCH_PERF_CNT_EN) flushed entries + dropped responses
// ----------------------------------------------------------------------------
module iiitb_rv32i_ifetch #(
    parameter int          FIFO_DEPTH = 4,
    parameter int          ADDR_W     = 10,
    parameter logic [31:0] RESET_PC   = 32'd0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    output logic              o_imem_req,
    output logic [ADDR_W-1:0] o_imem_addr,
    input  logic              i_imem_ready,
    input  logic              i_imem_rvalid,
    input  logic [31:0]       i_imem_rdata,
    input  logic              i_br_taken,
    input  logic [31:0]       i_br_target,
    output logic              o_if_valid,
    input  logic              i_if_ready,
    output logic [31:0]       o_if_instr,
    output logic [31:0]       o_if_npc
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0]       o_perf_fetched,
    output logic [31:0]       o_perf_flushed
`endif
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int CRED_W = PTR_W + 2;
    localparam logic [CRED_W-1:0] LP_DEPTH = CRED_W'(FIFO_DEPTH);

    typedef enum logic {
        S_FETCH,
        S_FLUSH
    } ifState_e;

    ifState_e          r_state;
    ifState_e          w_nextState;
    logic [31:0]       r_pc;
    logic [CNT_W-1:0]  r_outstanding;
    logic [CNT_W-1:0]  r_drop;
    logic [CNT_W-1:0]  r_count;
    logic [PTR_W-1:0]  r_wrPtr;
    logic [PTR_W-1:0]  r_rdPtr;
    logic [PTR_W-1:0]  r_tagWrPtr;
    logic [PTR_W-1:0]  r_tagRdPtr;
    logic              r_rstDly;
    logic [31:0]       r_fifoInstr [FIFO_DEPTH];
    logic [31:0]       r_fifoNpc   [FIFO_DEPTH];
    logic [31:0]       r_tagMem    [FIFO_DEPTH];

    logic [CRED_W-1:0] w_credits;
    logic              w_quiet;
    logic              w_req;
    logic              w_accept;
    logic              w_valid;
    logic              w_pop;
    logic              w_dropResp;
    logic              w_push;
    logic [CNT_W-1:0]  w_newDrop;

    // Outputs are silenced during reset and for one cycle after it, so the
    // memory (which shares the reset) sees a clean restart.
    assign w_quiet    = i_rst | r_rstDly;
    assign w_credits  = CRED_W'(r_count) + CRED_W'(r_outstanding);
    assign w_req      = (r_state == S_FETCH) & (w_credits < LP_DEPTH) &
                        ~i_br_taken & ~w_quiet;
    assign w_accept   = w_req & i_imem_ready;
    assign w_valid    = (r_count != '0) & ~i_br_taken & ~w_quiet;
    assign w_pop      = w_valid & i_if_ready;
    assign w_dropResp = i_imem_rvalid & (r_drop != '0);
    assign w_push     = i_imem_rvalid & (r_drop == '0) & ~i_br_taken;
    // The response arriving in the redirect cycle is consumed right away,
    // so only the reads still outstanding after it must be dropped.
    assign w_newDrop  = r_outstanding - CNT_W'(i_imem_rvalid);

    assign o_imem_req  = w_req;
    assign o_imem_addr = r_pc[ADDR_W-1:0];
    assign o_if_valid  = w_valid;
    assign o_if_instr  = r_fifoInstr[r_rdPtr];
    assign o_if_npc    = r_fifoNpc[r_rdPtr];

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next state: a redirect with stale reads in flight enters FLUSH. FLUSH
    // leaves once the drop counter has reached zero.
    always_comb begin
        w_nextState = r_state;
        if (i_br_taken) begin
            w_nextState = (w_newDrop != '0) ? S_FLUSH : S_FETCH;
        end else if ((r_state == S_FLUSH) && (r_drop == '0)) begin
            w_nextState = S_FETCH;
        end
    end

    // PC, counters and queue pointers. A redirect overrides all normal
    // updates in its cycle. No request or handshake can occur then anyway.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pc          <= RESET_PC;
            r_outstanding <= '0;
            r_drop        <= '0;
            r_count       <= '0;
            r_wrPtr       <= '0;
            r_rdPtr       <= '0;
            r_tagWrPtr    <= '0;
            r_tagRdPtr    <= '0;
            r_rstDly      <= 1'b1;
        end else begin
            r_rstDly <= 1'b0;
            if (i_br_taken) begin
                r_pc          <= i_br_target;
                r_outstanding <= w_newDrop;
                r_drop        <= w_newDrop;
                r_count       <= '0;
                r_wrPtr       <= '0;
                r_rdPtr       <= '0;
                r_tagWrPtr    <= '0;
                r_tagRdPtr    <= '0;
            end else begin
                r_outstanding <= r_outstanding + CNT_W'(w_accept) - CNT_W'(i_imem_rvalid);
                r_count       <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
                if (w_accept) begin
                    r_pc       <= r_pc + 32'd1;
                    r_tagWrPtr <= r_tagWrPtr + PTR_W'(1);
                end
                if (w_push) begin
                    r_wrPtr    <= r_wrPtr + PTR_W'(1);
                    r_tagRdPtr <= r_tagRdPtr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rdPtr <= r_rdPtr + PTR_W'(1);
                end
                if (w_dropResp) begin
                    r_drop <= r_drop - CNT_W'(1);
                end
            end
        end
    end

    // Storage arrays. They need no reset because they are only read
    // behind the counters.
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_tagMem[r_tagWrPtr] <= r_pc;
        end
        if (w_push) begin
            r_fifoInstr[r_wrPtr] <= i_imem_rdata;
            r_fifoNpc[r_wrPtr]   <= r_tagMem[r_tagRdPtr] + 32'd1;
        end
    end

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] r_perfFetched;
    logic [31:0] r_perfFlushed;
    logic [31:0] w_flushInc;
    logic [32:0] w_fetchedSum;
    logic [32:0] w_flushedSum;

    // A redirect discards every buffered entry plus any response landing
    // in the same cycle. Otherwise only drained stale responses count.
    assign w_flushInc   = i_br_taken ? (32'(r_count) + 32'(i_imem_rvalid))
                                     : 32'(w_dropResp);
    assign w_fetchedSum = {1'b0, r_perfFetched} + 33'(w_pop);
    assign w_flushedSum = {1'b0, r_perfFlushed} + {1'b0, w_flushInc};

    // Saturating performance counters.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_perfFetched <= '0;
            r_perfFlushed <= '0;
        end else begin
            r_perfFetched <= w_fetchedSum[32] ? 32'hFFFF_FFFF : w_fetchedSum[31:0];
            r_perfFlushed <= w_flushedSum[32] ? 32'hFFFF_FFFF : w_flushedSum[31:0];
        end
    end

    assign o_perf_fetched = r_perfFetched;
    assign o_perf_flushed = r_perfFlushed;
`endif

endmodule

// File: tb/tb_iiitb_rv32i_ifetch.sv
// ----------------------------------------------------------------------------
// Testbench for iiitb_rv32i_ifetch.
//
// The bench plays the instruction memory. The memory returns responses in
// order with a configurable latency and a randomly throttled ready. A
// reference model tracks which word address decode must receive next and
// which address the fetch unit must request next. A redirect resets both
// to the target; a reset resets both to RESET_PC.
// ----------------------------------------------------------------------------
module tb_iiitb_rv32i_ifetch;

    localparam int          ADDR_W   = 10;
    localparam logic [31:0] RESET_PC = 32'd0;

    logic              clk = 1'b0;
    logic              i_rst = 1'b1;
    logic              o_imem_req;
    logic [ADDR_W-1:0] o_imem_addr;
    logic              i_imem_ready = 1'b0;
    logic              i_imem_rvalid = 1'b0;
    logic [31:0]       i_imem_rdata = 32'd0;
    logic              i_br_taken = 1'b0;
    logic [31:0]       i_br_target = 32'd0;
    logic              o_if_valid;
    logic              i_if_ready = 1'b0;
    logic [31:0]       o_if_instr;
    logic [31:0]       o_if_npc;
`ifdef IFETCH_PERF_CNT_EN
    logic [31:0]       o_perf_fetched;
    logic [31:0]       o_perf_flushed;
`endif

    iiitb_rv32i_ifetch #(
        .FIFO_DEPTH (4),
        .ADDR_W     (ADDR_W),
        .RESET_PC   (RESET_PC)
    ) dut (
        .i_clk         (clk),
        .i_rst         (i_rst),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_ready  (i_imem_ready),
        .i_imem_rvalid (i_imem_rvalid),
        .i_imem_rdata  (i_imem_rdata),
        .i_br_taken    (i_br_taken),
        .i_br_target   (i_br_target),
        .o_if_valid    (o_if_valid),
        .i_if_ready    (i_if_ready),
        .o_if_instr    (o_if_instr),
        .o_if_npc      (o_if_npc)
`ifdef IFETCH_PERF_CNT_EN
        ,
        .o_perf_fetched (o_perf_fetched),
        .o_perf_flushed (o_perf_flushed)
`endif
    );

    always #5 clk = ~clk;

    int          checkCount = 0;
    int          errorCount = 0;
    int          cyc = 0;
    int          lat = 1;
    int          readyPct = 100;
    int          ifReadyPct = 100;
    logic [31:0] pendAddr [$];
    int          pendDue  [$];
    logic [31:0] expDeliver = RESET_PC;
    logic [31:0] expIssue = RESET_PC;
    bit          afterRst = 1'b0;
    bit          prevHold = 1'b0;
    bit          prevStallReq = 1'b0;
    logic [31:0] prevInstr = 32'd0;
    logic [31:0] prevNpc = 32'd0;
    logic [ADDR_W-1:0] prevAddr = '0;
    int          hsCount = 0;
    int          firstAcc = -1;
    int          firstValid = -1;
    int          rstCyc = 0;
    bit          seenHs = 1'b0;
    logic [31:0] firstHsNpc = 32'd0;
    bit          lastReqB = 1'b0;
    bit          lastValidB = 1'b0;
    logic [31:0] lastInstrB = 32'd0;

    // Memory contents: every address in the 1024-word space maps to a
    // distinct word.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        logic [9:0] w;
        w = a[9:0];
        return {6'h2A, w, 6'h15, w};
    endfunction

    // Counts a comparison and reports it when the values differ.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)",
                     tag, actual, expected, cyc);
        end
    endtask

    // One clock cycle: drive memory/decode/redirect inputs, check outputs
    // against the reference model, then advance to the next negedge.
    // brMode 0 = none, 1 = redirect now, 2 = redirect only together with a
    // decode handshake and a memory response, 3 = random redirect.
    task automatic applyStimulus(input bit rstIn, input int brMode,
                                 input logic [31:0] brTgt, output bit tookBr);
        bit                reqB;
        bit                validB;
        bit                takeBr;
        bit                hs;
        bit                acc;
        logic [31:0]       instrB;
        logic [31:0]       npcB;
        logic [ADDR_W-1:0] addrB;

        i_rst         = rstIn;
        i_imem_rvalid = 1'b0;
        i_imem_rdata  = $urandom;
        if (!rstIn && pendDue.size() > 0 && pendDue[0] <= cyc) begin
            i_imem_rvalid = 1'b1;
            i_imem_rdata  = memWord(pendAddr[0]);
        end
        i_imem_ready = (int'($urandom_range(99)) < readyPct);
        i_if_ready   = (int'($urandom_range(99)) < ifReadyPct);
        i_br_taken   = 1'b0;
        i_br_target  = $urandom;
        #1;
        reqB   = o_imem_req;
        validB = o_if_valid;
        instrB = o_if_instr;
        npcB   = o_if_npc;
        addrB  = o_imem_addr;

        takeBr = 1'b0;
        if (!rstIn) begin
            case (brMode)
                1: takeBr = 1'b1;
                2: takeBr = validB && i_if_ready && i_imem_rvalid;
                3: takeBr = ($urandom_range(99) < 5);
                default: takeBr = 1'b0;
            endcase
        end
        if (takeBr) begin
            i_br_taken  = 1'b1;
            i_br_target = brTgt;
            #1;
        end
        tookBr = takeBr;

        if (rstIn || afterRst) begin
            checkOutput("rstReq", 32'(o_imem_req), 32'd0);
            checkOutput("rstValid", 32'(o_if_valid), 32'd0);
`ifdef IFETCH_PERF_CNT_EN
            if (afterRst) begin
                checkOutput("rstPerfFetched", o_perf_fetched, 32'd0);
                checkOutput("rstPerfFlushed", o_perf_flushed, 32'd0);
            end
`endif
        end
        if (takeBr) begin
            checkOutput("brValid", 32'(o_if_valid), 32'd0);
            checkOutput("brReq", 32'(o_imem_req), 32'd0);
        end
        if (!rstIn && prevHold) begin
            checkOutput("holdValid", 32'(validB), 32'd1);
            checkOutput("holdInstr", instrB, prevInstr);
            checkOutput("holdNpc", npcB, prevNpc);
        end
        if (!rstIn && prevStallReq) begin
            checkOutput("holdReq", 32'(reqB), 32'd1);
            checkOutput("holdAddr", 32'(addrB), 32'(prevAddr));
        end

        hs  = !rstIn && o_if_valid && i_if_ready;
        acc = !rstIn && o_imem_req && i_imem_ready;
        if (hs) begin
            checkOutput("instr", o_if_instr, memWord(expDeliver));
            checkOutput("npc", o_if_npc, expDeliver + 32'd1);
            if (!seenHs) begin
                seenHs     = 1'b1;
                firstHsNpc = o_if_npc;
            end
            expDeliver = expDeliver + 32'd1;
            hsCount++;
        end
        if (acc) begin
            checkOutput("issueAddr", 32'(o_imem_addr), 32'(expIssue[ADDR_W-1:0]));
            pendAddr.push_back(32'(o_imem_addr));
            pendDue.push_back(cyc + lat);
            expIssue = expIssue + 32'd1;
            if (firstAcc < 0) firstAcc = cyc;
        end
        if (i_imem_rvalid) begin
            void'(pendAddr.pop_front());
            void'(pendDue.pop_front());
        end
        if (!rstIn && validB && firstValid < 0) firstValid = cyc;

        prevHold     = !rstIn && !takeBr && o_if_valid && !i_if_ready;
        prevStallReq = !rstIn && !takeBr && o_imem_req && !i_imem_ready;
        prevInstr    = o_if_instr;
        prevNpc      = o_if_npc;
        prevAddr     = o_imem_addr;
        lastReqB     = reqB;
        lastValidB   = validB;
        lastInstrB   = instrB;

        if (takeBr) begin
            expDeliver = brTgt;
            expIssue   = brTgt;
            seenHs     = 1'b0;
        end
        afterRst = rstIn;
        if (rstIn) begin
            pendAddr.delete();
            pendDue.delete();
            expDeliver = RESET_PC;
            expIssue   = RESET_PC;
            firstAcc   = -1;
            firstValid = -1;
            rstCyc     = cyc;
            seenHs     = 1'b0;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        bit          took;
        int          h0;
        logic [31:0] tgt;

        @(negedge clk);

        // Reset, latency 1, always ready: startup latency and throughput.
        lat = 1; readyPct = 100; ifReadyPct = 100;
        applyStimulus(1'b1, 0, 32'd0, took);
        applyStimulus(1'b1, 0, 32'd0, took);
        repeat (12) applyStimulus(1'b0, 0, 32'd0, took);
        checkOutput("firstIssueCycle", 32'(firstAcc - rstCyc), 32'd2);
        checkOutput("firstLatency", 32'(firstValid - firstAcc), 32'(lat + 1));
        h0 = hsCount;
        repeat (30) applyStimulus(1'b0, 0, 32'd0, took);
        checkOutput("throughput", 32'(hsCount - h0), 32'd30);

        // Decode stalls: FIFO fills, requests stop, release drains back to back.
        ifReadyPct = 0;
        repeat (20) applyStimulus(1'b0, 0, 32'd0, took);
        checkOutput("fullReq", 32'(lastReqB), 32'd0);
        checkOutput("fullValid", 32'(lastValidB), 32'd1);
        checkOutput("fullInstr", lastInstrB, memWord(expDeliver));
        ifReadyPct = 100;
        h0 = hsCount;
        repeat (4) applyStimulus(1'b0, 0, 32'd0, took);
        checkOutput("drainBurst", 32'(hsCount - h0), 32'd4);

        // Latency 3, redirect to 40 with two reads in flight.
        applyStimulus(1'b1, 0, 32'd0, took);
        lat = 3;
        took = 1'b0;
        for (int i = 0; i < 30 && !took; i++)
            applyStimulus(1'b0, (pendAddr.size() >= 2) ? 1 : 0, 32'd40, took);
        checkOutput("s3Redirect", 32'(took), 32'd1);
        repeat (30) applyStimulus(1'b0, 0, 32'd0, took);
        checkOutput("s3Seen", 32'(seenHs), 32'd1);
        checkOutput("s3FirstNpc", firstHsNpc, 32'd41);

        // Redirect coinciding with a handshake and a memory response.
        lat = 1;
        took = 1'b0;
        for (int i = 0; i < 50 && !took; i++)
            applyStimulus(1'b0, 2, 32'd200, took);
        checkOutput("s4Redirect", 32'(took), 32'd1);
        repeat (20) applyStimulus(1'b0, 0, 32'd0, took);
        checkOutput("s4FirstNpc", firstHsNpc, 32'd201);

        // Address wrap at the top of the 10-bit memory.
        applyStimulus(1'b0, 1, 32'd1023, took);
        repeat (20) applyStimulus(1'b0, 0, 32'd0, took);
        checkOutput("s5FirstNpc", firstHsNpc, 32'd1024);

        // Reset in the middle of a flush.
        lat = 5; ifReadyPct = 0;
        repeat (6) applyStimulus(1'b0, 0, 32'd0, took);
        applyStimulus(1'b0, 1, 32'd300, took);
        applyStimulus(1'b0, 0, 32'd0, took);
        applyStimulus(1'b1, 0, 32'd0, took);
        lat = 1; ifReadyPct = 100;
        repeat (20) applyStimulus(1'b0, 0, 32'd0, took);
        checkOutput("s6Restart", firstHsNpc, RESET_PC + 32'd1);

        // Randomized traffic with random redirects, including targets that
        // wrap the 32-bit PC.
        readyPct = 60; ifReadyPct = 60;
        for (int chunk = 0; chunk < 6; chunk++) begin
            lat = int'($urandom_range(4, 1));
            h0  = hsCount;
            repeat (100) begin
                tgt = ($urandom_range(3) == 0) ? 32'hFFFF_FFFE : $urandom;
                applyStimulus(1'b0, 3, tgt, took);
            end
            checkOutput("randProgress", 32'(hsCount > h0), 32'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
